// File: rtl/axis_routed_switch_pkg.sv
// Shared definitions for the routed AXI4-Stream switch: input FSM states,
// readback ID address and the settings-bus counter-reset offset.
package axis_routed_switch_pkg;

  localparam logic [7:0] RB_ID_ADDR = 8'hFF;

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, FWD, DROP} in_state_t;

  // Counter-reset register sits just past the end of the routing table.
  function automatic logic [31:0] cnt_rst_offset(input int tbl_aw);
    return 32'd1 << tbl_aw;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter: grants one requester and holds the grant until the
// release strobe, re-arbitrating in the releasing cycle.
module axis_rr_arbiter
  import axis_routed_switch_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic               release_stb,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] rot_req, first_req;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;

  // Rotate so ptr_reg is bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot_req    = NUM_REQ'({req, req} >> ptr_reg);
    first_req  = rot_req & (-rot_req);
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    if (release_stb || (grant_reg == '0)) begin
      grant_next = NUM_REQ'(({first_req, first_req} << ptr_reg) >> NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_next[i]) ptr_next = IDX_W'((i + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign grant = grant_reg;

endmodule

// File: rtl/axis_routed_switch.sv
// N-input x M-output AXI4-Stream packet switch routed by a DST lookup table,
// with per-output round-robin arbitration, drop of unroutable packets and counters.
module axis_routed_switch
  import axis_routed_switch_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int WIDTH       = 64,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int DST_LSB     = 0,
  parameter int TBL_AW      = 8,
  parameter int OUT_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [NUM_INPUTS*WIDTH-1:0]  i_tdata,
  input  logic [NUM_INPUTS-1:0]        i_tvalid,
  input  logic [NUM_INPUTS-1:0]        i_tlast,
  output logic [NUM_INPUTS-1:0]        i_tready,
  output logic [NUM_OUTPUTS*WIDTH-1:0] o_tdata,
  output logic [NUM_OUTPUTS-1:0]       o_tvalid,
  output logic [NUM_OUTPUTS-1:0]       o_tlast,
  input  logic [NUM_OUTPUTS-1:0]       o_tready,
  input  logic                         set_stb,
  input  logic [15:0]                  set_addr,
  input  logic [31:0]                  set_data,
  input  logic                         rb_rd_stb,
  input  logic [7:0]                   rb_addr,
  output logic [31:0]                  rb_data,
  output logic                         rb_valid
);

  localparam int TBL_DEPTH = 2 ** TBL_AW;

  logic [31:0] set_off;
  logic        tbl_we, cnt_rst;
  logic        unused_set_bits;

  assign set_off = 32'(set_addr) - 32'(BASE);
  assign tbl_we  = set_stb && (32'(set_addr) >= 32'(BASE)) && (set_off < 32'(TBL_DEPTH));
  assign cnt_rst = set_stb && (32'(set_addr) == 32'(BASE) + cnt_rst_offset(TBL_AW));
  assign unused_set_bits = ^set_data[31:OUT_W];

  logic [OUT_W-1:0] route_tbl_reg [TBL_DEPTH];

  // The table survives clear; only a hard reset returns every entry to port 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TBL_DEPTH; i++) route_tbl_reg[i] <= '0;
    end else if (tbl_we) begin
      route_tbl_reg[set_off[TBL_AW-1:0]] <= set_data[OUT_W-1:0];
    end
  end

  logic [NUM_INPUTS-1:0][OUT_W-1:0]      entry_all;
  logic [NUM_INPUTS-1:0]                 in_req, in_fwd, granted, tgt_ready;
  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] req_mat, grant_mat;
  logic [NUM_INPUTS-1:0][31:0]           drop_cnt;
  logic [NUM_OUTPUTS-1:0][31:0]          pkt_cnt;

  always_comb begin
    req_mat   = '0;
    granted   = '0;
    tgt_ready = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (entry_all[k] == OUT_W'(j)) begin
          req_mat[j][k] = in_req[k];
          granted[k]    = granted[k] | grant_mat[j][k];
          tgt_ready[k]  = tgt_ready[k] | o_tready[j];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    in_state_t        st_reg, st_next;
    logic [OUT_W-1:0] entry_reg;
    logic [31:0]      drop_cnt_reg;
    logic             rdy, beat_last;

    assign beat_last = i_tvalid[gi] & rdy & i_tlast[gi];

    always_comb begin
      st_next = st_reg;
      rdy     = 1'b0;
      case (st_reg)
        IDLE:    if (i_tvalid[gi]) st_next = LOOKUP;
        LOOKUP:  st_next = (32'(entry_reg) < 32'(NUM_OUTPUTS)) ? REQ : DROP;
        REQ:     if (granted[gi]) st_next = FWD;
        FWD: begin
          rdy = tgt_ready[gi];
          if (beat_last) st_next = IDLE;
        end
        DROP: begin
          rdy = 1'b1;
          if (beat_last) st_next = IDLE;
        end
        default: st_next = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset || clear) begin
        st_reg       <= IDLE;
        entry_reg    <= '0;
        drop_cnt_reg <= '0;
      end else begin
        st_reg <= st_next;
        if (st_reg == IDLE && i_tvalid[gi])
          entry_reg <= route_tbl_reg[i_tdata[gi*WIDTH+DST_LSB +: TBL_AW]];
        if (cnt_rst)
          drop_cnt_reg <= '0;
        else if (st_reg == DROP && beat_last)
          drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
    end

    assign i_tready[gi]  = rdy;
    assign in_req[gi]    = (st_reg == REQ);
    assign in_fwd[gi]    = (st_reg == FWD);
    assign entry_all[gi] = entry_reg;
    assign drop_cnt[gi]  = drop_cnt_reg;
  end

  // An output carries an input only once that input has reached FWD, so a fresh
  // grant cannot produce a beat the input has not agreed to hand over.
  always_comb begin
    o_tdata  = '0;
    o_tvalid = '0;
    o_tlast  = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (grant_mat[j][k] && in_fwd[k]) begin
          o_tdata[j*WIDTH +: WIDTH] = o_tdata[j*WIDTH +: WIDTH] | i_tdata[k*WIDTH +: WIDTH];
          o_tvalid[j] = o_tvalid[j] | i_tvalid[k];
          o_tlast[j]  = o_tlast[j] | i_tlast[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
    logic        pkt_done;
    logic [31:0] pkt_cnt_reg;

    assign pkt_done = o_tvalid[gi] & o_tready[gi] & o_tlast[gi];

    axis_rr_arbiter #(.NUM_REQ(NUM_INPUTS)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .req         (req_mat[gi]),
      .release_stb (pkt_done),
      .grant       (grant_mat[gi])
    );

    always_ff @(posedge clk) begin
      if (!reset || clear || cnt_rst) pkt_cnt_reg <= '0;
      else if (pkt_done)              pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
    end

    assign pkt_cnt[gi] = pkt_cnt_reg;
  end

  logic       rb_valid_reg;
  logic [7:0] rb_addr_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rb_valid_reg <= 1'b0;
      rb_addr_reg  <= '0;
    end else begin
      rb_valid_reg <= rb_rd_stb;
      if (rb_rd_stb) rb_addr_reg <= rb_addr;
    end
  end

  always_comb begin
    rb_data = '0;
    if (rb_valid_reg) begin
      if (rb_addr_reg == RB_ID_ADDR) begin
        rb_data = {24'h0, 4'(NUM_INPUTS), 4'(NUM_OUTPUTS)};
      end else begin
        for (int j = 0; j < NUM_OUTPUTS; j++)
          if (rb_addr_reg == 8'(j)) rb_data = pkt_cnt[j];
        for (int k = 0; k < NUM_INPUTS; k++)
          if (rb_addr_reg == 8'(NUM_OUTPUTS + k)) rb_data = drop_cnt[k];
      end
    end
  end

  assign rb_valid = rb_valid_reg;

endmodule

// File: tb/tb_axis_routed_switch.sv
// Directed bench for axis_routed_switch (4x4, 64-bit): routing, contention,
// drop, backpressure, reset/clear mid-packet and readback.
module tb_axis_routed_switch;

  localparam int W  = 64;
  localparam int NI = 4;
  localparam int NO = 4;

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [NI*W-1:0] i_tdata;
  logic [NI-1:0]   i_tvalid, i_tlast, i_tready;
  logic [NO*W-1:0] o_tdata;
  logic [NO-1:0]   o_tvalid, o_tlast, o_tready;
  logic            set_stb;
  logic [15:0]     set_addr;
  logic [31:0]     set_data;
  logic            rb_rd_stb;
  logic [7:0]      rb_addr;
  logic [31:0]     rb_data;
  logic            rb_valid;

  axis_routed_switch dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_rd_stb(rb_rd_stb), .rb_addr(rb_addr), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  logic [W-1:0] tdata_arr [NI];
  logic         vld_arr   [NI];
  logic         last_arr  [NI];

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      i_tdata[k*W +: W] = tdata_arr[k];
      i_tvalid[k]       = vld_arr[k];
      i_tlast[k]        = last_arr[k];
    end
  end

  typedef struct packed {
    logic [1:0]   port;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  beat_t mon_q[$];

  always @(negedge clk) begin
    for (int j = 0; j < NO; j++) begin
      if (o_tvalid[j] && o_tready[j]) begin
        beat_t b;
        b.port = 2'(j);
        b.last = o_tlast[j];
        b.data = o_tdata[j*W +: W];
        mon_q.push_back(b);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int p, input int tag, input int w, input int dst);
    return {8'(p), 8'(tag), 8'(w), 32'hC0DE_0000, 8'(dst)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rb_rd_stb = 1'b1; rb_addr = a;
    @(posedge clk); #1;
    rb_rd_stb = 1'b0;
    @(negedge clk);
    check_eq("rb_valid", rb_valid, 1'b1);
    d = rb_data;
    @(posedge clk); #1;
  endtask

  // Sends words 0..n_stop-1 with handshakes; if n_stop < n, word n_stop is
  // left presented so the caller can abandon the packet mid-flight.
  task automatic send_pkt(input int p, input int dst, input int n, input int tag,
                          input int n_stop, output int lat);
    int cyc;
    bit ok;
    lat = 0;
    for (int w = 0; w < n_stop; w++) begin
      tdata_arr[p] = mkword(p, tag, w, dst);
      vld_arr[p]   = 1'b1;
      last_arr[p]  = (w == n - 1);
      cyc = 0;
      do begin
        @(negedge clk);
        ok = i_tready[p];
        @(posedge clk); #1;
        cyc++;
      end while (!ok && cyc < 300);
      if (!ok) check_eq("send_timeout", cyc, 0);
      if (w == 0) lat = cyc;
    end
    if (n_stop < n) begin
      tdata_arr[p] = mkword(p, tag, n_stop, dst);
      last_arr[p]  = (n_stop == n - 1);
    end else begin
      vld_arr[p]  = 1'b0;
      last_arr[p] = 1'b0;
    end
  endtask

  task automatic expect_pkt(input int port, input int src, input int tag, input int dst, input int n);
    beat_t b;
    for (int w = 0; w < n; w++) begin
      if (mon_q.size() == 0) begin
        check_eq("beat_missing", w, n);
        return;
      end
      b = mon_q.pop_front();
      check_eq("out_port", b.port, port);
      check_eq("out_data", b.data, mkword(src, tag, w, dst));
      check_eq("out_last", b.last, (w == n - 1));
    end
    $display("rx port=%0d src=%0d tag=%0d words=%0d", port, src, tag, n);
  endtask

  int          lat0, lat1, lat3;
  logic [31:0] rdv;
  logic [63:0] held;
  bit          stalled;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0; o_tready = '1;
    set_stb = 1'b0; set_addr = '0; set_data = '0;
    rb_rd_stb = 1'b0; rb_addr = '0;
    for (int k = 0; k < NI; k++) begin
      tdata_arr[k] = '0; vld_arr[k] = 1'b0; last_arr[k] = 1'b0;
    end

    // reset state
    idle(3);
    @(negedge clk);
    check_eq("rst_o_tvalid", o_tvalid, 0);
    check_eq("rst_i_tready", i_tready, 0);
    check_eq("rst_o_tdata", o_tdata[63:0], 0);
    check_eq("rst_rb_valid", rb_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // route DST=5 -> output 2
    wr(16'd5, 32'd2);
    send_pkt(0, 5, 4, 1, 4, lat0);
    check_eq("latency_min3", (lat0 >= 3), 1'b1);
    idle(6);
    check_eq("route_beats", mon_q.size(), 4);
    expect_pkt(2, 0, 1, 5, 4);
    rd(8'd2, rdv);
    check_eq("pkt_cnt2", rdv, 1);

    // contention: inputs 0,1,3 each send two packets to output 1
    wr(16'd7, 32'd1);
    fork
      begin send_pkt(0, 7, 3, 0,  3, lat0); send_pkt(0, 7, 3, 1,  3, lat0); end
      begin send_pkt(1, 7, 3, 10, 3, lat1); send_pkt(1, 7, 3, 11, 3, lat1); end
      begin send_pkt(3, 7, 3, 30, 3, lat3); send_pkt(3, 7, 3, 31, 3, lat3); end
    join
    idle(6);
    check_eq("cont_beats", mon_q.size(), 18);
    expect_pkt(1, 0, 0,  7, 3);
    expect_pkt(1, 1, 10, 7, 3);
    expect_pkt(1, 3, 30, 7, 3);
    expect_pkt(1, 0, 1,  7, 3);
    expect_pkt(1, 1, 11, 7, 3);
    expect_pkt(1, 3, 31, 7, 3);
    rd(8'd1, rdv);
    check_eq("pkt_cnt1", rdv, 6);

    // drop: entry 9 -> 15 (no such output)
    wr(16'd9, 32'd15);
    send_pkt(2, 9, 3, 40, 3, lat0);
    idle(6);
    check_eq("drop_no_output", mon_q.size(), 0);
    rd(8'd6, rdv);
    check_eq("drop_cnt2", rdv, 1);

    // counter reset write
    wr(16'd256, 32'd0);
    rd(8'd6, rdv);
    check_eq("drop_cnt2_zeroed", rdv, 0);
    rd(8'd1, rdv);
    check_eq("pkt_cnt1_zeroed", rdv, 0);

    // backpressure on output 0 (DST=3 uses default entry 0)
    stalled = 1'b0;
    held    = '0;
    fork
      send_pkt(1, 3, 6, 50, 6, lat1);
      begin
        for (int c = 0; c < 40; c++) begin
          o_tready[0] = ~o_tready[0];
          @(negedge clk);
          if (stalled && o_tvalid[0]) check_eq("stall_hold", o_tdata[63:0], held);
          stalled = o_tvalid[0] && !o_tready[0];
          held    = o_tdata[63:0];
          @(posedge clk); #1;
        end
        o_tready[0] = 1'b1;
      end
    join
    idle(4);
    check_eq("bp_beats", mon_q.size(), 6);
    expect_pkt(0, 1, 50, 3, 6);

    // reset during word 2 of a 5-word packet
    send_pkt(0, 5, 5, 60, 1, lat0);
    reset = 1'b0;
    @(posedge clk); #1;
    vld_arr[0] = 1'b0; last_arr[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_o_tvalid", o_tvalid, 0);
    check_eq("rst_mid_i_tready", i_tready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    mon_q.delete();
    send_pkt(0, 5, 1, 61, 1, lat0);
    idle(6);
    check_eq("tbl_reset_beats", mon_q.size(), 1);
    expect_pkt(0, 0, 61, 5, 1);

    // clear mid-packet keeps table, zeroes counters
    wr(16'd5, 32'd2);
    send_pkt(0, 5, 2, 70, 2, lat0);
    idle(6);
    expect_pkt(2, 0, 70, 5, 2);
    rd(8'd2, rdv);
    check_eq("pkt_cnt2_pre_clear", rdv, 1);
    send_pkt(0, 5, 5, 71, 2, lat0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vld_arr[0] = 1'b0; last_arr[0] = 1'b0;
    @(negedge clk);
    check_eq("clr_o_tvalid", o_tvalid, 0);
    @(posedge clk); #1;
    mon_q.delete();
    rd(8'd2, rdv);
    check_eq("pkt_cnt2_cleared", rdv, 0);
    send_pkt(0, 5, 1, 72, 1, lat0);
    idle(6);
    check_eq("tbl_kept_beats", mon_q.size(), 1);
    expect_pkt(2, 0, 72, 5, 1);

    // readback ID and an unmapped address
    rd(8'hFF, rdv);
    check_eq("rb_id", rdv, 32'h44);
    @(negedge clk);
    check_eq("rb_valid_pulse", rb_valid, 0);
    @(posedge clk); #1;
    rd(8'h20, rdv);
    check_eq("rb_unmapped", rdv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
